// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO router: FSM state type, tag field
// geometry inside the 32-bit byte address, and the default base tag.
package mmio_pkg;

    // The region tag lives in the top twelve address bits
    localparam int TAG_W   = 12;
    localparam int TAG_LSB = 20;

    // Tag owned by slave 0 unless the instance overrides it
    localparam logic [TAG_W-1:0] DEFAULT_BASE_TAG = 12'h001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mmio_router_if.sv
// Bus bundle between one master, the router and NUM_SLV slaves.
// The "slave" modport is the router's view (it is the slave of the master
// and drives the shared slave-side request); "master" is the opposite view,
// used by whatever drives requests and models the slaves.
interface mmio_router_if #(
    parameter int NUM_SLV = 6,
    parameter int DW      = 32
) ();

    logic                  m_req;
    logic                  m_we;
    logic [31:0]           m_addr;
    logic [DW-1:0]         m_wdata;
    logic                  m_ack;
    logic [DW-1:0]         m_rdata;
    logic                  m_err;

    logic [NUM_SLV-1:0]    s_sel;
    logic                  s_we;
    logic [31:0]           s_addr;
    logic [DW-1:0]         s_wdata;
    logic [NUM_SLV*DW-1:0] s_rdata;
    logic [NUM_SLV-1:0]    s_ack;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
        output m_ack, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
        input  m_ack, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
    );

endinterface

// File: rtl/mmio_decode.sv
// Combinational region decoder: maps an address tag to a one-hot slave
// select and a hit flag. Slave i owns tag BASE_TAG+i.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int               NUM_SLV  = 6,
    parameter logic [TAG_W-1:0] BASE_TAG = DEFAULT_BASE_TAG
) (
    input  logic [TAG_W-1:0]   tag,
    output logic [NUM_SLV-1:0] sel,
    output logic               hit
);

    logic [TAG_W-1:0] offset;

    // Subtract in TAG_W bits so tags below BASE_TAG wrap to large offsets and miss
    always_comb begin
        offset = tag - BASE_TAG;
        hit    = (offset < TAG_W'(NUM_SLV));
        sel    = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel[i] = hit && (offset == TAG_W'(i));
        end
    end

endmodule

// File: rtl/mmio_router.sv
// Single-master MMIO router. Decodes the address tag of a master request,
// forwards the latched request to one slave and returns its completion as a
// one-cycle m_ack. Unmapped tags complete immediately with m_err.
// Optional access watchdog: define MMIO_ROUTER_TIMEOUT_EN to end an ACCESS
// that sees no s_ack within TIMEOUT cycles with a bus error.
module mmio_router
    import mmio_pkg::*;
#(
    parameter int               NUM_SLV  = 6,
    parameter logic [TAG_W-1:0] BASE_TAG = DEFAULT_BASE_TAG,
    parameter int               DW       = 32,
    parameter int               TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         rst,
    mmio_router_if.slave bus
);

    state_t             state_q, state_d;
    logic               m_ack_q, m_ack_d;
    logic [DW-1:0]      m_rdata_q, m_rdata_d;
    logic               m_err_q, m_err_d;
    logic [NUM_SLV-1:0] s_sel_q, s_sel_d;
    logic               s_we_q, s_we_d;
    logic [31:0]        s_addr_q, s_addr_d;
    logic [DW-1:0]      s_wdata_q, s_wdata_d;

    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_hit;
    logic               sel_ack;
    logic [DW-1:0]      sel_rdata;

`ifdef MMIO_ROUTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    // Without the watchdog TIMEOUT has no effect; keep it referenced for elaboration
    if (TIMEOUT < 2) begin : g_timeout_unused
    end
`endif

    mmio_decode #(
        .NUM_SLV  (NUM_SLV),
        .BASE_TAG (BASE_TAG)
    ) u_decode (
        .tag (bus.m_addr[TAG_LSB +: TAG_W]),
        .sel (dec_sel),
        .hit (dec_hit)
    );

    // Only the selected slave may complete; acks from other slaves are masked off
    assign sel_ack = |(bus.s_ack & s_sel_q);

    // Pick the read data slice of the selected slave via the one-hot select
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (s_sel_q[i]) begin
                sel_rdata = sel_rdata | bus.s_rdata[i*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below
    always_comb begin
        state_d   = state_q;
        m_ack_d   = 1'b0;
        m_rdata_d = m_rdata_q;
        m_err_d   = m_err_q;
        s_sel_d   = s_sel_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
`ifdef MMIO_ROUTER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.m_req) begin
                    s_we_d    = bus.m_we;
                    s_addr_d  = bus.m_addr;
                    s_wdata_d = bus.m_wdata;
                    if (dec_hit) begin
                        state_d = ACCESS;
                        s_sel_d = dec_sel;
`ifdef MMIO_ROUTER_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d   = RESP;
                        m_ack_d   = 1'b1;
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    state_d   = RESP;
                    m_ack_d   = 1'b1;
                    m_err_d   = 1'b0;
                    m_rdata_d = s_we_q ? '0 : sel_rdata;
                    s_sel_d   = '0;
                end
`ifdef MMIO_ROUTER_TIMEOUT_EN
                else if (timed_out) begin
                    state_d   = RESP;
                    m_ack_d   = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = '0;
                    s_sel_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_ack_q   <= 1'b0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
            s_sel_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
`ifdef MMIO_ROUTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            m_ack_q   <= m_ack_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
            s_sel_q   <= s_sel_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
`ifdef MMIO_ROUTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.m_ack   = m_ack_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.m_err   = m_err_q;
    assign bus.s_sel   = s_sel_q;
    assign bus.s_we    = s_we_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;

endmodule

// File: tb/tb_mmio_router.sv
// Scoreboard bench for mmio_router. The stimulus task computes each
// expected response from the address map rules and queues it; a monitor
// pops the queue whenever m_ack is seen. Honours MMIO_ROUTER_TIMEOUT_EN.
module tb_mmio_router;

    localparam int          NUM_SLV  = 6;
    localparam int          DW       = 32;
    localparam logic [11:0] BASE_TAG = 12'h001;
    localparam int          TIMEOUT  = 16;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    resp_t         exp_q[$];
    resp_t         mon_exp;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err   = 1'b0;

    mmio_router_if #(.NUM_SLV(NUM_SLV), .DW(DW)) bus ();

    mmio_router #(
        .NUM_SLV  (NUM_SLV),
        .BASE_TAG (BASE_TAG),
        .DW       (DW),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each completion with the oldest queued expectation,
    // and check that m_rdata/m_err hold between completions
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            last_rdata = '0;
            last_err   = 1'b0;
        end else if (bus.m_ack) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_m_ack", 64'(bus.m_ack), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("m_rdata", 64'(bus.m_rdata), 64'(mon_exp.rdata));
                check_output("m_err", 64'(bus.m_err), 64'(mon_exp.err));
                last_rdata = mon_exp.rdata;
                last_err   = mon_exp.err;
            end
        end else begin
            check_output("m_rdata_hold", 64'(bus.m_rdata), 64'(last_rdata));
            check_output("m_err_hold", 64'(bus.m_err), 64'(last_err));
        end
    end

    // One complete master transaction with a modelled slave answering after 'delay' cycles
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [DW-1:0] wdata,
                                  input logic [DW-1:0] rdata, input int delay);
        logic [11:0]        off;
        bit                 hit;
        int                 idx;
        logic [NUM_SLV-1:0] sel_bit;
        int                 cyc;
        int                 nwait;
        int                 exp_lat;
        bit                 give_ack;
        resp_t              e;

        off     = addr[31:20] - BASE_TAG;
        hit     = (off < NUM_SLV);
        idx     = int'(off);
        sel_bit = '0;
        if (hit) sel_bit[idx] = 1'b1;

        nwait    = delay;
        give_ack = 1'b1;
`ifdef MMIO_ROUTER_TIMEOUT_EN
        if (delay >= TIMEOUT) begin
            nwait    = TIMEOUT;
            give_ack = 1'b0;
        end
`endif
        e.err   = !hit || !give_ack;
        e.rdata = (hit && give_ack && !we) ? rdata : '0;
        exp_lat = !hit ? 1 : (give_ack ? delay + 2 : TIMEOUT + 1);

        @(negedge clk);
        bus.m_req   = 1'b1;
        bus.m_we    = we;
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
        exp_q.push_back(e);
        for (int i = 0; i < NUM_SLV; i++) bus.s_rdata[i*DW +: DW] = $urandom();
        if (hit) bus.s_rdata[idx*DW +: DW] = rdata;

        @(negedge clk);
        cyc = 1;
        bus.m_we    = 1'($urandom());
        bus.m_addr  = $urandom();
        bus.m_wdata = $urandom();
        if (hit) begin
            check_output("s_we", 64'(bus.s_we), 64'(we));
            check_output("s_addr", 64'(bus.s_addr), 64'(addr));
            check_output("s_wdata", 64'(bus.s_wdata), 64'(wdata));
            for (int d = 0; d < nwait; d++) begin
                check_output("s_sel_wait", 64'(bus.s_sel), 64'(sel_bit));
                check_output("m_ack_early", 64'(bus.m_ack), 64'd0);
                bus.s_ack = NUM_SLV'($urandom()) & ~sel_bit;
                @(negedge clk);
                cyc++;
            end
            if (give_ack) begin
                check_output("s_sel_ack", 64'(bus.s_sel), 64'(sel_bit));
                bus.s_ack = NUM_SLV'($urandom()) | sel_bit;
                @(negedge clk);
                cyc++;
            end
            bus.s_ack = '0;
        end else begin
            check_output("s_sel_miss", 64'(bus.s_sel), 64'd0);
        end

        while (!bus.m_ack && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check_output("latency", 64'(cyc), 64'(exp_lat));
        check_output("s_sel_cleared", 64'(bus.s_sel), 64'd0);
        bus.m_req = 1'b0;
        @(negedge clk);
        check_output("m_ack_pulse", 64'(bus.m_ack), 64'd0);
    endtask

    // Abandon a read with a reset pulse while the slave is being accessed
    task automatic reset_in_access(input logic [31:0] addr);
        logic [11:0]        off;
        logic [NUM_SLV-1:0] sel_bit;

        off     = addr[31:20] - BASE_TAG;
        sel_bit = '0;
        sel_bit[int'(off)] = 1'b1;

        @(negedge clk);
        bus.m_req  = 1'b1;
        bus.m_we   = 1'b0;
        bus.m_addr = addr;
        @(negedge clk);
        check_output("s_sel_before_rst", 64'(bus.s_sel), 64'(sel_bit));
        bus.s_ack = '0;
        bus.m_req = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("s_sel_after_rst", 64'(bus.s_sel), 64'd0);
        check_output("m_ack_after_rst", 64'(bus.m_ack), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check_output("no_ack_after_rst", 64'(bus.m_ack), 64'd0);
        end
    endtask

    // Safety net so a stuck design still ends the run
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [11:0] tag;
        int          r;

        rst         = 1'b1;
        bus.m_req   = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_ack   = '0;
        bus.s_rdata = '0;
        repeat (2) @(negedge clk);
        check_output("rst_m_ack", 64'(bus.m_ack), 64'd0);
        check_output("rst_m_err", 64'(bus.m_err), 64'd0);
        check_output("rst_m_rdata", 64'(bus.m_rdata), 64'd0);
        check_output("rst_s_sel", 64'(bus.s_sel), 64'd0);
        check_output("rst_s_we", 64'(bus.s_we), 64'd0);
        check_output("rst_s_addr", 64'(bus.s_addr), 64'd0);
        check_output("rst_s_wdata", 64'(bus.s_wdata), 64'd0);
        rst = 1'b0;

        $display("[TB] directed transactions");
        apply_stimulus(1'b0, 32'h0020_0000, 32'h0, 32'hDEAD_BEEF, 0);
        apply_stimulus(1'b1, 32'h0010_0004, 32'h55, 32'hCAFE_F00D, 0);
        apply_stimulus(1'b0, 32'h0070_0000, 32'h0, 32'h1111_2222, 0);
        apply_stimulus(1'b0, 32'h0000_0000, 32'h0, 32'h3333_4444, 0);
        apply_stimulus(1'b0, 32'h0060_0010, 32'h0, 32'hA5A5_5A5A, 2);
        apply_stimulus(1'b0, 32'hFFF0_0000, 32'h0, 32'h7777_8888, 0);
        apply_stimulus(1'b0, 32'h0040_0000, 32'h0, 32'h0BAD_CAFE, 3);
        apply_stimulus(1'b0, 32'h0030_0000, 32'h0, 32'h1234_5678, TIMEOUT);
        apply_stimulus(1'b0, 32'h0050_0000, 32'h0, 32'h8765_4321, TIMEOUT - 1);

        reset_in_access(32'h0030_0000);
        apply_stimulus(1'b0, 32'h0030_0000, 32'h0, 32'h0F0F_F0F0, 1);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) tag = 12'(r);
            else       tag = 12'($urandom());
            apply_stimulus(1'($urandom()), {tag, 20'($urandom())}, $urandom(), $urandom(),
                           $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
